// File: rtl/uart_sample_buf_pkg.sv
// Shared definitions for the UART sample buffer: parameter defaults and FSM state encoding.
package uart_sample_buf_pkg;

    localparam int DW_DEF       = 12;
    localparam int TONE_LEN_DEF = 256;
    localparam int QPSK_LEN_DEF = 768;
    localparam int AW_DEF       = 10;

    typedef enum logic [1:0] {
        S_TONE = 2'd0,
        S_QPSK = 2'd1,
        S_FULL = 2'd2
    } state_t;

endpackage

// File: rtl/uart_sample_buf_if.sv
// Sample-in / read-out / status bundle of the sample buffer; slave is the buffer side.
interface uart_sample_buf_if
    import uart_sample_buf_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int AW = AW_DEF
);

    logic [DW-1:0] din_12_a;
    logic [DW-1:0] din_12_b;
    logic          din_12_valid;
    logic          frame_clr;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data_a;
    logic [DW-1:0] rd_data_b;
    logic          rd_valid;
    logic          tone_signal_wr_done;
    logic          qpsk_signal_wr_done;
    logic          buf_full;
    logic          overflow;

    modport master (
        output din_12_a, din_12_b, din_12_valid, frame_clr, rd_en, rd_addr,
        input  rd_data_a, rd_data_b, rd_valid, tone_signal_wr_done,
               qpsk_signal_wr_done, buf_full, overflow
    );

    modport slave (
        input  din_12_a, din_12_b, din_12_valid, frame_clr, rd_en, rd_addr,
        output rd_data_a, rd_data_b, rd_valid, tone_signal_wr_done,
               qpsk_signal_wr_done, buf_full, overflow
    );

endinterface

// File: rtl/uart_sample_buf_sample_bram.sv
// Simple dual-port RAM with a registered, read-first output port.
module sample_bram #(
    parameter int W  = 24,
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [2**AW];

    // NOTE: the array is deliberately left out of reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    // A same-address write lands after this read, so the old word is returned.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)     rdata <= '0;
        else if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/uart_sample_buf.sv
// Captures one tone frame then one QPSK frame of a/b sample pairs into a shared buffer.
module uart_sample_buf
    import uart_sample_buf_pkg::*;
#(
    parameter int DW       = DW_DEF,
    parameter int TONE_LEN = TONE_LEN_DEF,
    parameter int QPSK_LEN = QPSK_LEN_DEF,
    parameter int AW       = AW_DEF
) (
    input logic             clk,
    input logic             rst,
    uart_sample_buf_if.slave bus
);

    localparam int            TOTAL     = TONE_LEN + QPSK_LEN;
    localparam logic [AW-1:0] TONE_LAST = AW'(TONE_LEN - 1);
    localparam logic [AW-1:0] QPSK_LAST = AW'(TOTAL - 1);

    state_t        state_q, state_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic          overflow_q, overflow_d;
    logic          tone_done_q, tone_done_d;
    logic          qpsk_done_q, qpsk_done_d;
    logic          rd_valid_q;
    logic          wr_en;
    logic [2*DW-1:0] rdata;

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        overflow_d  = overflow_q;
        tone_done_d = 1'b0;
        qpsk_done_d = 1'b0;
        wr_en       = 1'b0;
        if (bus.frame_clr) begin
            state_d    = S_TONE;
            wr_ptr_d   = '0;
            overflow_d = 1'b0;
        end else if (bus.din_12_valid) begin
            unique case (state_q)
                S_TONE: begin
                    wr_en    = 1'b1;
                    wr_ptr_d = wr_ptr_q + AW'(1);
                    if (wr_ptr_q == TONE_LAST) begin
                        state_d     = S_QPSK;
                        tone_done_d = 1'b1;
                    end
                end
                S_QPSK: begin
                    wr_en    = 1'b1;
                    wr_ptr_d = wr_ptr_q + AW'(1);
                    if (wr_ptr_q == QPSK_LAST) begin
                        state_d     = S_FULL;
                        qpsk_done_d = 1'b1;
                    end
                end
                S_FULL:  overflow_d = 1'b1;
                default: state_d    = S_TONE;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so all of them update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_TONE;
            wr_ptr_q    <= '0;
            overflow_q  <= 1'b0;
            tone_done_q <= 1'b0;
            qpsk_done_q <= 1'b0;
            rd_valid_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            overflow_q  <= overflow_d;
            tone_done_q <= tone_done_d;
            qpsk_done_q <= qpsk_done_d;
            rd_valid_q  <= bus.rd_en;
        end
    end

    sample_bram #(
        .W  (2 * DW),
        .AW (AW)
    ) u_bram (
        .clk   (clk),
        .rst   (rst),
        .we    (wr_en),
        .waddr (wr_ptr_q),
        .wdata ({bus.din_12_a, bus.din_12_b}),
        .re    (bus.rd_en),
        .raddr (bus.rd_addr),
        .rdata (rdata)
    );

    assign bus.rd_data_a           = rdata[2*DW-1:DW];
    assign bus.rd_data_b           = rdata[DW-1:0];
    assign bus.rd_valid            = rd_valid_q;
    assign bus.tone_signal_wr_done = tone_done_q;
    assign bus.qpsk_signal_wr_done = qpsk_done_q;
    assign bus.buf_full            = (state_q == S_FULL);
    assign bus.overflow            = overflow_q;

endmodule

// File: tb/tb_uart_sample_buf.sv
// Scenario bench for uart_sample_buf with small frames and a fill-count reference model.
module tb_uart_sample_buf;

    localparam int DW    = 12;
    localparam int AW    = 4;
    localparam int TL    = 4;
    localparam int QL    = 4;
    localparam int TOTAL = TL + QL;
    localparam int DEPTH = 2**AW;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    uart_sample_buf_if #(.DW(DW), .AW(AW)) bus ();

    uart_sample_buf #(.DW(DW), .TONE_LEN(TL), .QPSK_LEN(QL), .AW(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: how many pairs are stored, plus a plain copy of the buffer.
    int            fill;
    bit            ovf;
    logic [DW-1:0] m_a [DEPTH];
    logic [DW-1:0] m_b [DEPTH];
    bit            m_known [DEPTH];
    bit            exp_tone, exp_qpsk, exp_full, exp_known;
    logic [DW-1:0] exp_ra, exp_rb;

    int tone_cnt = 0;
    int qpsk_cnt = 0;
    always @(negedge clk) begin
        if (bus.tone_signal_wr_done === 1'b1) tone_cnt++;
        if (bus.qpsk_signal_wr_done === 1'b1) qpsk_cnt++;
    end

    task automatic model_reset();
        fill     = 0;
        ovf      = 1'b0;
        exp_tone = 1'b0;
        exp_qpsk = 1'b0;
        exp_full = 1'b0;
    endtask

    // One clock of stimulus; afterwards the model holds what the outputs should show.
    task automatic cycle(input bit v, input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input bit c, input bit re, input int ra);
        bus.din_12_valid = v;
        bus.din_12_a     = a;
        bus.din_12_b     = b;
        bus.frame_clr    = c;
        bus.rd_en        = re;
        bus.rd_addr      = AW'(ra);
        @(posedge clk);
        #1;
        bus.din_12_valid = 1'b0;
        bus.frame_clr    = 1'b0;
        bus.rd_en        = 1'b0;
        if (re) begin
            exp_known = m_known[ra];
            exp_ra    = m_a[ra];
            exp_rb    = m_b[ra];
        end
        exp_tone = 1'b0;
        exp_qpsk = 1'b0;
        if (c) begin
            fill = 0;
            ovf  = 1'b0;
        end else if (v) begin
            if (fill == TOTAL) ovf = 1'b1;
            else begin
                m_a[fill]     = a;
                m_b[fill]     = b;
                m_known[fill] = 1'b1;
                fill++;
                exp_tone = (fill == TL);
                exp_qpsk = (fill == TOTAL);
            end
        end
        exp_full = (fill == TOTAL);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, '0, '0, 1'b0, 1'b0, 0);
    endtask

    task automatic strobe(input logic [DW-1:0] a, input logic [DW-1:0] b);
        cycle(1'b1, a, b, 1'b0, 1'b0, 0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #2;
        total++; if (bus.tone_signal_wr_done !== 1'b0) begin bad++; $display("FAIL reset_tone got=%b exp=0", bus.tone_signal_wr_done); end
        total++; if (bus.qpsk_signal_wr_done !== 1'b0) begin bad++; $display("FAIL reset_qpsk got=%b exp=0", bus.qpsk_signal_wr_done); end
        total++; if (bus.buf_full !== 1'b0) begin bad++; $display("FAIL reset_full got=%b exp=0", bus.buf_full); end
        total++; if (bus.overflow !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b exp=0", bus.overflow); end
        total++; if (bus.rd_valid !== 1'b0) begin bad++; $display("FAIL reset_rd_valid got=%b exp=0", bus.rd_valid); end
        total++; if (bus.rd_data_a !== '0) begin bad++; $display("FAIL reset_rd_a got=%h exp=0", bus.rd_data_a); end
        total++; if (bus.rd_data_b !== '0) begin bad++; $display("FAIL reset_rd_b got=%h exp=0", bus.rd_data_b); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_fill();
        int t0 = tone_cnt;
        int q0 = qpsk_cnt;
        for (int i = 0; i < TOTAL; i++) begin
            strobe(DW'(i), DW'(12'hFFF - i));
            total++; if (bus.tone_signal_wr_done !== exp_tone) begin bad++; $display("FAIL fill_tone strobe=%0d got=%b exp=%b", i + 1, bus.tone_signal_wr_done, exp_tone); end
            total++; if (bus.qpsk_signal_wr_done !== exp_qpsk) begin bad++; $display("FAIL fill_qpsk strobe=%0d got=%b exp=%b", i + 1, bus.qpsk_signal_wr_done, exp_qpsk); end
            total++; if (bus.buf_full !== exp_full) begin bad++; $display("FAIL fill_full strobe=%0d got=%b exp=%b", i + 1, bus.buf_full, exp_full); end
            idle($urandom_range(0, 2));
        end
        for (int i = 0; i < TOTAL; i++) begin
            cycle(1'b0, '0, '0, 1'b0, 1'b1, i);
            total++; if (bus.rd_valid !== 1'b1) begin bad++; $display("FAIL fill_rd_valid addr=%0d got=%b exp=1", i, bus.rd_valid); end
            total++; if (bus.rd_data_a !== DW'(i)) begin bad++; $display("FAIL fill_rd_a addr=%0d got=%h exp=%h", i, bus.rd_data_a, DW'(i)); end
            total++; if (bus.rd_data_b !== exp_rb) begin bad++; $display("FAIL fill_rd_b addr=%0d got=%h exp=%h", i, bus.rd_data_b, exp_rb); end
        end
        idle(1);
        total++; if (bus.rd_valid !== 1'b0) begin bad++; $display("FAIL fill_rd_valid_idle got=%b exp=0", bus.rd_valid); end
        total++; if (tone_cnt - t0 !== 1) begin bad++; $display("FAIL fill_tone_count got=%0d exp=1", tone_cnt - t0); end
        total++; if (qpsk_cnt - q0 !== 1) begin bad++; $display("FAIL fill_qpsk_count got=%0d exp=1", qpsk_cnt - q0); end
    endtask

    task automatic test_overflow();
        int t0 = tone_cnt;
        int q0 = qpsk_cnt;
        strobe(DW'($urandom), DW'($urandom));
        total++; if (bus.overflow !== ovf) begin bad++; $display("FAIL ovf_flag got=%b exp=%b", bus.overflow, ovf); end
        total++; if (bus.buf_full !== exp_full) begin bad++; $display("FAIL ovf_full got=%b exp=%b", bus.buf_full, exp_full); end
        idle(2);
        total++; if (bus.overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%b exp=1", bus.overflow); end
        cycle(1'b0, '0, '0, 1'b0, 1'b1, TOTAL - 1);
        total++; if (bus.rd_data_a !== exp_ra || bus.rd_data_b !== exp_rb) begin bad++; $display("FAIL ovf_addr7 got=%h/%h exp=%h/%h", bus.rd_data_a, bus.rd_data_b, exp_ra, exp_rb); end
        total++; if (tone_cnt - t0 + qpsk_cnt - q0 !== 0) begin bad++; $display("FAIL ovf_extra_pulse got=%0d exp=0", tone_cnt - t0 + qpsk_cnt - q0); end
    endtask

    task automatic test_clr_collision();
        int t0;
        cycle(1'b0, '0, '0, 1'b1, 1'b0, 0);
        total++; if (bus.buf_full !== 1'b0) begin bad++; $display("FAIL clr_full got=%b exp=0", bus.buf_full); end
        total++; if (bus.overflow !== 1'b0) begin bad++; $display("FAIL clr_ovf got=%b exp=0", bus.overflow); end
        t0 = tone_cnt;
        strobe(DW'($urandom), DW'($urandom));
        strobe(DW'($urandom), DW'($urandom));
        cycle(1'b1, DW'($urandom), DW'($urandom), 1'b1, 1'b0, 0);
        total++; if (bus.overflow !== 1'b0) begin bad++; $display("FAIL clr_coll_ovf got=%b exp=0", bus.overflow); end
        for (int i = 0; i < TL; i++) begin
            strobe(DW'($urandom), DW'($urandom));
            total++; if (bus.tone_signal_wr_done !== exp_tone) begin bad++; $display("FAIL clr_coll_tone strobe=%0d got=%b exp=%b", i + 1, bus.tone_signal_wr_done, exp_tone); end
        end
        idle(1);
        total++; if (tone_cnt - t0 !== 1) begin bad++; $display("FAIL clr_coll_tone_count got=%0d exp=1", tone_cnt - t0); end
        for (int i = 0; i < TL; i++) begin
            cycle(1'b0, '0, '0, 1'b0, 1'b1, i);
            total++; if (bus.rd_data_a !== exp_ra || bus.rd_data_b !== exp_rb) begin bad++; $display("FAIL clr_coll_data addr=%0d got=%h/%h exp=%h/%h", i, bus.rd_data_a, bus.rd_data_b, exp_ra, exp_rb); end
        end
    endtask

    task automatic test_reset_midframe();
        int t0;
        cycle(1'b0, '0, '0, 1'b1, 1'b0, 0);
        t0 = tone_cnt;
        strobe(DW'($urandom), DW'($urandom));
        strobe(DW'($urandom), DW'($urandom));
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < TL; i++) strobe(DW'($urandom), DW'($urandom));
        idle(2);
        total++; if (tone_cnt - t0 !== 1) begin bad++; $display("FAIL rst_mid_tone_count got=%0d exp=1", tone_cnt - t0); end
        for (int i = 0; i < TL; i++) begin
            cycle(1'b0, '0, '0, 1'b0, 1'b1, i);
            total++; if (bus.rd_data_a !== exp_ra || bus.rd_data_b !== exp_rb) begin bad++; $display("FAIL rst_mid_data addr=%0d got=%h/%h exp=%h/%h", i, bus.rd_data_a, bus.rd_data_b, exp_ra, exp_rb); end
        end
    endtask

    task automatic test_read_first();
        logic [DW-1:0] b_new;
        cycle(1'b0, '0, '0, 1'b1, 1'b0, 0);
        for (int i = 0; i < 5; i++) strobe(DW'($urandom), DW'($urandom));
        b_new = DW'($urandom);
        cycle(1'b1, 12'hABC, b_new, 1'b0, 1'b1, 5);
        total++; if (!exp_known || bus.rd_data_a !== exp_ra || bus.rd_data_b !== exp_rb) begin bad++; $display("FAIL read_first_old got=%h/%h exp=%h/%h", bus.rd_data_a, bus.rd_data_b, exp_ra, exp_rb); end
        cycle(1'b0, '0, '0, 1'b0, 1'b1, 5);
        total++; if (bus.rd_data_a !== 12'hABC) begin bad++; $display("FAIL read_first_new_a got=%h exp=abc", bus.rd_data_a); end
        total++; if (bus.rd_data_b !== b_new) begin bad++; $display("FAIL read_first_new_b got=%h exp=%h", bus.rd_data_b, b_new); end
    endtask

    task automatic test_back_to_back();
        int t0 = tone_cnt;
        int q0 = qpsk_cnt;
        int ra;
        cycle(1'b0, '0, '0, 1'b1, 1'b0, 0);
        for (int i = 0; i < TOTAL; i++) begin
            ra = $urandom_range(0, TOTAL - 1);
            cycle(1'b1, DW'($urandom), DW'($urandom), 1'b0, 1'b1, ra);
            total++; if (bus.rd_valid !== 1'b1) begin bad++; $display("FAIL b2b_rd_valid cyc=%0d got=%b exp=1", i, bus.rd_valid); end
            if (exp_known) begin
                total++; if (bus.rd_data_a !== exp_ra || bus.rd_data_b !== exp_rb) begin bad++; $display("FAIL b2b_concurrent addr=%0d got=%h/%h exp=%h/%h", ra, bus.rd_data_a, bus.rd_data_b, exp_ra, exp_rb); end
            end
        end
        total++; if (bus.buf_full !== 1'b1) begin bad++; $display("FAIL b2b_full got=%b exp=1", bus.buf_full); end
        for (int i = 0; i < TOTAL; i++) begin
            cycle(1'b0, '0, '0, 1'b0, 1'b1, i);
            total++; if (bus.rd_valid !== 1'b1 || bus.rd_data_a !== exp_ra || bus.rd_data_b !== exp_rb) begin bad++; $display("FAIL b2b_data addr=%0d got=%b:%h/%h exp=1:%h/%h", i, bus.rd_valid, bus.rd_data_a, bus.rd_data_b, exp_ra, exp_rb); end
        end
        cycle(1'b0, '0, '0, 1'b0, 1'b1, DEPTH - 3);
        total++; if (bus.rd_valid !== 1'b1) begin bad++; $display("FAIL out_of_range_rd_valid got=%b exp=1", bus.rd_valid); end
        idle(1);
        total++; if (bus.rd_valid !== 1'b0) begin bad++; $display("FAIL b2b_rd_valid_idle got=%b exp=0", bus.rd_valid); end
        total++; if (tone_cnt - t0 !== 1 || qpsk_cnt - q0 !== 1) begin bad++; $display("FAIL b2b_pulse_count got=%0d/%0d exp=1/1", tone_cnt - t0, qpsk_cnt - q0); end
    endtask

    initial begin
        bus.din_12_valid = 1'b0;
        bus.din_12_a     = '0;
        bus.din_12_b     = '0;
        bus.frame_clr    = 1'b0;
        bus.rd_en        = 1'b0;
        bus.rd_addr      = '0;
        for (int i = 0; i < DEPTH; i++) m_known[i] = 1'b0;
        model_reset();
        test_reset();
        test_fill();
        test_overflow();
        test_clr_collision();
        test_reset_midframe();
        test_read_first();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
